// File: rtl/section_peak_meter.sv
// Per-channel section peak meter: tracks the largest magnitude per channel over
// SAMPLE_COUNT frames, then emits one beat per channel from a double buffer.
module section_peak_meter #(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_COUNT = 3,
  parameter int SIGNED_IN    = 0,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_value,
  input  logic [CW-1:0]    i_channel,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_value,
  output logic [CW-1:0]    o_channel,
  output logic             o_last,
  output logic             o_sync_err
);
  localparam int FW = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  localparam logic [FW-1:0] LAST_FR = FW'(SAMPLE_COUNT - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                         state, state_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0] run_max, buf_max, upd;
  logic [CW-1:0]                  exp_ch, beat_ch;
  logic [FW-1:0]                  frame_cnt;
  logic                           ready_en, sync_err_q;
  logic [WIDTH-1:0]               mag;
  logic                           accept, take, would_end, sec_end, beat_done, last_done;

  // Most-negative input has no positive counterpart, so it saturates.
  always_comb begin
    mag = i_value;
    if (SIGNED_IN != 0 && i_value[WIDTH-1]) begin
      if (i_value == {1'b1, {(WIDTH-1){1'b0}}}) mag = {1'b0, {(WIDTH-1){1'b1}}};
      else                                       mag = ~i_value + 1'b1;
    end
  end

  assign accept    = i_valid && i_ready;
  assign take      = accept && (i_channel == exp_ch);
  assign would_end = (exp_ch == LAST_CH) && (frame_cnt == LAST_FR);
  assign sec_end   = take && would_end;
  assign beat_done = o_valid && o_ready;
  assign last_done = beat_done && o_last;

  // Buffer still occupied: refuse the sample that would need to overwrite it.
  assign i_ready = ready_en && !(state == EMIT && would_end);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign upd[c] = (take && exp_ch == CW'(c) && mag > run_max[c]) ? mag : run_max[c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max    <= '0;
      buf_max    <= '0;
      exp_ch     <= '0;
      frame_cnt  <= '0;
      ready_en   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      sync_err_q <= accept && !take;
      if (sec_end) begin
        buf_max <= upd;
        run_max <= '0;
      end else begin
        run_max <= upd;
      end
      if (take) begin
        if (exp_ch == LAST_CH) begin
          exp_ch    <= '0;
          frame_cnt <= (frame_cnt == LAST_FR) ? '0 : frame_cnt + 1'b1;
        end else begin
          exp_ch <= exp_ch + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      beat_ch <= '0;
    end else begin
      state <= state_nxt;
      if (sec_end)        beat_ch <= '0;
      else if (beat_done) beat_ch <= o_last ? '0 : beat_ch + 1'b1;
    end
  end

  // A section ending on the o_last edge reloads the buffer and stays in EMIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sec_end) state_nxt = EMIT;
      EMIT:    if (last_done && !sec_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_valid    = (state == EMIT);
    o_channel  = beat_ch;
    o_last     = o_valid && (beat_ch == LAST_CH);
    o_value    = o_valid ? buf_max[beat_ch] : '0;
    o_sync_err = sync_err_q;
  end
endmodule

// File: tb/tb_section_peak_meter.sv
// Directed bench for section_peak_meter: unsigned and signed instances, beats
// checked against a queue of expected per-section maxima.
module tb_section_peak_meter;
  logic        clk = 1'b0;
  logic        reset;
  logic        iv   [2];
  logic [15:0] ival [2];
  logic        ich  [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [15:0] oval [2];
  logic        och  [2];
  logic        olast[2];
  logic        serr [2];

  int          vecs = 0;
  int          errs = 0;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] e0, e1;

  always #5 clk = ~clk;

  section_peak_meter #(.WIDTH(16), .CHANNELS(2), .SAMPLE_COUNT(3), .SIGNED_IN(0)) u0 (
    .clk(clk), .reset(reset), .i_valid(iv[0]), .i_ready(ir[0]), .i_value(ival[0]),
    .i_channel(ich[0]), .o_valid(ov[0]), .o_ready(ordy[0]), .o_value(oval[0]),
    .o_channel(och[0]), .o_last(olast[0]), .o_sync_err(serr[0]));

  section_peak_meter #(.WIDTH(16), .CHANNELS(2), .SAMPLE_COUNT(3), .SIGNED_IN(1)) u1 (
    .clk(clk), .reset(reset), .i_valid(iv[1]), .i_ready(ir[1]), .i_value(ival[1]),
    .i_channel(ich[1]), .o_valid(ov[1]), .o_ready(ordy[1]), .o_value(oval[1]),
    .o_channel(och[1]), .o_last(olast[1]), .o_sync_err(serr[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] magf(input int u, input logic [15:0] v);
    if (u == 0 || !v[15]) return v;
    if (v == 16'h8000)    return 16'h7fff;
    return 16'h0000 - v;
  endfunction

  function automatic logic [15:0] max3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [15:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Beats are checked on the falling edge ahead of the accepting rising edge.
  always @(negedge clk) begin
    if (ov[0] && ordy[0]) begin
      chk("beat0_pending", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("beat0", {14'd0, och[0], olast[0], oval[0]}, {14'd0, e0});
      end
    end
    if (ov[1] && ordy[1]) begin
      chk("beat1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("beat1", {14'd0, och[1], olast[1], oval[1]}, {14'd0, e1});
      end
    end
  end

  task automatic send(input int u, input logic ch, input logic [15:0] v);
    int n = 0;
    @(negedge clk);
    iv[u] = 1'b1; ival[u] = v; ich[u] = ch;
    while (!ir[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(ir[u]), 32'd1);
    else @(posedge clk);
    #1 iv[u] = 1'b0;
  endtask

  task automatic send_sec(input int u, input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1,
                          input logic [15:0] a2, input logic [15:0] b2, input int nsend);
    logic [15:0] s[6];
    logic [15:0] m0, m1;
    m0 = max3(magf(u, a0), magf(u, a1), magf(u, a2));
    m1 = max3(magf(u, b0), magf(u, b1), magf(u, b2));
    if (u == 0) begin q0.push_back({2'b00, m0}); q0.push_back({2'b11, m1}); end
    else        begin q1.push_back({2'b00, m0}); q1.push_back({2'b11, m1}); end
    s[0] = a0; s[1] = b0; s[2] = a1; s[3] = b1; s[4] = a2; s[5] = b2;
    for (int i = 0; i < nsend; i++) send(u, i[0], s[i]);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; ival[u] = '0; ich[u] = 1'b0; ordy[u] = 1'b1;
    end
    #12;
    chk("rst_o_valid", 32'(ov[0]), 32'd0);
    chk("rst_o_value", 32'(oval[0]), 32'd0);
    chk("rst_o_channel", 32'(och[0]), 32'd0);
    chk("rst_o_last", 32'(olast[0]), 32'd0);
    chk("rst_sync_err", 32'(serr[0]), 32'd0);
    chk("rst_i_ready", 32'(ir[0]), 32'd0);
    @(negedge clk) reset = 1'b1;
    #1 chk("ready_before_edge", 32'(ir[0]), 32'd0);
    @(negedge clk) chk("ready_after_reset", 32'(ir[0]), 32'd1);

    // Basic unsigned section and one-cycle output latency
    send_sec(0, 16'h1111, 16'h2222, 16'h0000, 16'h6666, 16'h4444, 16'h5555, 6);
    @(negedge clk) chk("latency_o_valid", 32'(ov[0]), 32'd1);

    // Back-to-back sections; all-zero section shows maxima were cleared
    send_sec(0, 16'h2222, 16'h8888, 16'h3333, 16'heeee, 16'h1111, 16'hffff, 6);
    send_sec(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6);
    drain();

    // Out-of-order sample is flagged and dropped
    send(0, 1'b1, 16'hffff);
    @(negedge clk) chk("sync_err_pulse", 32'(serr[0]), 32'd1);
    @(negedge clk) chk("sync_err_clear", 32'(serr[0]), 32'd0);
    send_sec(0, 16'h0010, 16'h0020, 16'h0030, 16'h0001, 16'h0005, 16'h0006, 6);
    drain();

    // Backpressure across two sections
    ordy[0] = 1'b0;
    send_sec(0, 16'h1000, 16'h2000, 16'h1500, 16'h2500, 16'h1200, 16'h2200, 6);
    @(negedge clk) chk("ready_during_emit", 32'(ir[0]), 32'd1);
    send_sec(0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 5);
    @(negedge clk);
    chk("ready_blocked", 32'(ir[0]), 32'd0);
    chk("held_o_valid", 32'(ov[0]), 32'd1);
    chk("held_o_value", 32'(oval[0]), 32'h1500);
    ordy[0] = 1'b1;
    send(0, 1'b1, 16'h0600);
    drain();

    // Reset mid-EMIT with a partial next section pending
    ordy[0] = 1'b0;
    send_sec(0, 16'h7000, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 16'h7005, 6);
    send(0, 1'b0, 16'h9999);
    send(0, 1'b1, 16'h9999);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_o_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_o_value", 32'(oval[0]), 32'd0);
    chk("mid_rst_o_last", 32'(olast[0]), 32'd0);
    chk("mid_rst_o_channel", 32'(och[0]), 32'd0);
    chk("mid_rst_i_ready", 32'(ir[0]), 32'd0);
    q0.delete();
    @(negedge clk) reset = 1'b1;
    ordy[0] = 1'b1;
    send_sec(0, 16'h0003, 16'h0004, 16'h0002, 16'h0001, 16'h0001, 16'h0002, 6);
    drain();

    // Signed magnitudes with saturation of the most-negative value
    send_sec(1, 16'h8000, 16'hffff, 16'h0001, 16'h7ff0, 16'hfffe, 16'h0002, 6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
